mux_sel_arbiter: RTL and testbench

- Round-robin arbiter sharing the 8-input select multiplexer between 8 requesters.
- Drives the mux 3-bit select line and a one-hot grant vector.
- Holds each grant until the owner signals done, withdraws its request, or a hold timeout expires.
- Sits between the requester logic and the mux select input; when enabled, replaces the static scrambler-driven select.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_sel_arbiter_rr_pick8.sv | 27 ++
 rtl/mux_sel_arbiter.sv | 110 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux select arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request after 'last', wrapping 7->0.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Offset 8 wraps back to 'last' itself, so a lone re-requester still wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select and a one-hot grant vector.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             owner_drop;
  logic             hold_max;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign owner_drop = ~req[sel_q];
  assign hold_max   = (hold_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_win;
          grant_d = onehot(pick_win);
          last_d  = pick_win;
          busy_d  = 1'b1;
          hold_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (done || owner_drop || hold_max) begin
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          // A forced release only counts as a timeout when nothing else ended the grant.
          timeout_d = hold_max && !done && !owner_drop;
        end else if (!hold_max) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= SEL_W'(N_REQ - 1);
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_grant_matches_sel : assert property (@(posedge clk) disable iff (rst)
    (grant_q != '0) |-> (grant_q == onehot(sel_q)));

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with hand-computed expectations.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  mux_sel_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    step();
    step();
    chk("rst_grant", grant, 8'h00);
    chk("rst_sel", sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b0;

    // Single requester, released by done
    req = 8'h01;
    step();
    chk("r0_grant", grant, 8'h01);
    chk("r0_sel", sel, 3'd0);
    chk("r0_busy", busy, 1'b1);
    done = 1'b1;
    step();
    chk("r0_rel_grant", grant, 8'h00);
    chk("r0_rel_sel", sel, 3'd0);
    chk("r0_rel_busy", busy, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();
    chk("idle_grant", grant, 8'h00);
    chk("idle_sel_hold", sel, 3'd0);

    // Pulse reset between edges to bring the pointer back to 7
    #2 rst = 1'b1;
    #1 rst = 1'b0;

    // All requesting: order 0..7 then 0, one dead cycle between grants
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_grant", grant, 32'h1 << (k % 8));
      chk("rr_sel", sel, k % 8);
      done = 1'b1;
      step();
      chk("rr_dead", grant, 8'h00);
      chk("rr_dead_sel", sel, k % 8);
      done = 1'b0;
    end

    // Get last=3, then req bits 0 and 3 must pick 0 by wrap
    req = 8'h08;
    step();
    chk("l3_grant", grant, 8'h08);
    done = 1'b1;
    step();
    chk("l3_rel", grant, 8'h00);
    done = 1'b0;
    req  = 8'h09;
    step();
    chk("wrap_grant", grant, 8'h01);
    chk("wrap_sel", sel, 3'd0);
    done = 1'b1;
    step();
    done = 1'b0;

    // Hold timeout: 16 grant cycles then forced release
    req = 8'h10;
    step();
    chk("to_grant", grant, 8'h10);
    chk("to_sel", sel, 3'd4);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_hold_grant", grant, 8'h10);
      chk("to_hold_pulse", timeout, 1'b0);
    end
    step();
    chk("to_rel_grant", grant, 8'h00);
    chk("to_rel_pulse", timeout, 1'b1);
    chk("to_rel_busy", busy, 1'b0);
    chk("to_rel_sel", sel, 3'd4);
    step();
    chk("to_regrant", grant, 8'h10);
    chk("to_pulse_end", timeout, 1'b0);
    done = 1'b1;
    step();
    chk("to_done_rel", grant, 8'h00);
    chk("to_done_pulse", timeout, 1'b0);
    done = 1'b0;

    // Owner 2 withdraws while 5 waits
    req = 8'h04;
    step();
    chk("drop_grant2", grant, 8'h04);
    req = 8'h24;
    step();
    chk("drop_ignore5", grant, 8'h04);
    req = 8'h20;
    step();
    chk("drop_rel", grant, 8'h00);
    chk("drop_pulse", timeout, 1'b0);
    chk("drop_sel", sel, 3'd2);
    step();
    chk("drop_next", grant, 8'h20);
    chk("drop_next_sel", sel, 3'd5);

    // done coinciding with the hold limit is a normal release
    for (int i = 0; i < 15; i++) step();
    chk("both_pre", grant, 8'h20);
    done = 1'b1;
    step();
    chk("both_rel", grant, 8'h00);
    chk("both_pulse", timeout, 1'b0);
    done = 1'b0;
    step();
    chk("mid_grant", grant, 8'h20);

    // Async reset mid-grant
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", grant, 8'h00);
    chk("arst_sel", sel, 3'd0);
    chk("arst_busy", busy, 1'b0);
    req = 8'h0A;
    #1 rst = 1'b0;
    step();
    chk("arst_first", grant, 8'h02);
    chk("arst_first_sel", sel, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
